// File: rtl/pe_block_drain.sv
// Requantizes completed 8-lane PE ofmap columns to int8 and streams the packed words to the output buffer.
// Latency: an i_valid rising edge in cycle T gives o_valid in T+2 when the FIFO is empty (first-word fall-through).
// Backpressure: o_ready low holds the FIFO head steady; a word arriving at a full FIFO is dropped and flagged.

module pe_drain_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module pe_block_drain #(
    parameter int ROWS       = 8,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       num_words,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    input  logic                    i_valid,
    input  logic signed [ACC_W-1:0] ofmap [0:ROWS-1],
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [ROWS*OUT_W-1:0]   o_data,
    output logic [ADDR_W-1:0]       o_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_num;
    logic [4:0]          r_shift;
    logic                r_relu;
    logic [ADDR_W-1:0]   r_cap_cnt;
    logic [ADDR_W-1:0]   r_sent_cnt;
    logic [ADDR_W-1:0]   r_drop_cnt;
    logic                r_ivld_prev;
    logic                r_stage_vld;
    logic [ROWS*OUT_W-1:0] r_stage_dat;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;

    logic [ROWS*OUT_W-1:0] w_req;
    logic [ROWS*OUT_W-1:0] w_fifo_dat;
    logic                w_capture;
    logic                w_start_ok;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic [ADDR_W:0]     w_resolved;
    logic                w_run_complete;

    // Rounding arithmetic shift in ACC_W+1 bits so adding the half-LSB can never wrap.
    function automatic logic [OUT_W-1:0] requant(
        input logic signed [ACC_W-1:0] x,
        input logic [4:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W:0] v;
        logic signed [ACC_W:0] rnd;
        v   = {x[ACC_W-1], x};
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = (ACC_W+1)'(1) << (sh - 5'd1);
            v   = (v + rnd) >>> sh;
        end
        if (relu && v[ACC_W]) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            v = SAT_MAX;
        end else if (v < SAT_MIN) begin
            v = SAT_MIN;
        end
        return v[OUT_W-1:0];
    endfunction

    always_comb begin
        w_req = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_req[r*OUT_W +: OUT_W] = requant(ofmap[r], r_shift, r_relu);
        end
    end

    assign w_capture      = (r_state == S_RUN) && i_valid && !r_ivld_prev && (r_cap_cnt < r_num);
    assign w_start_ok     = start && (r_state != S_RUN);
    assign w_pop          = o_valid && o_ready;
    assign w_drop         = r_stage_vld && w_full && !w_pop;
    assign w_resolved     = (ADDR_W+1)'(r_sent_cnt) + (ADDR_W+1)'(r_drop_cnt);
    assign w_run_complete = (w_resolved == {1'b0, r_num});

    pe_drain_fifo #(
        .W     (ROWS*OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_stage_vld),
        .i_dat   (r_stage_dat),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_dat   (w_fifo_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ivld_prev <= 1'b0;
            r_stage_vld <= 1'b0;
            r_stage_dat <= '0;
        end else begin
            r_ivld_prev <= i_valid;
            r_stage_vld <= w_capture;
            if (w_capture) begin
                r_stage_dat <= w_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_num      <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_cap_cnt  <= '0;
            r_sent_cnt <= '0;
            r_drop_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_base  <= base_addr;
                        r_num   <= num_words;
                        r_shift <= shift;
                        r_relu  <= relu_en;
                    end
                end
                S_RUN: begin
                    if (w_run_complete) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

            if (w_capture) begin
                r_cap_cnt <= r_cap_cnt + 1'b1;
            end
            if (w_pop) begin
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
                r_overflow <= 1'b1;
            end

            // A new run starts from clean counters; nothing is in flight outside RUN.
            if (w_start_ok) begin
                r_cap_cnt  <= '0;
                r_sent_cnt <= '0;
                r_drop_cnt <= '0;
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_valid  = !w_empty;
    assign o_data   = w_fifo_dat;
    assign o_addr   = r_base + r_sent_cnt;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_pe_block_drain.sv
// Randomized scoreboard bench for pe_block_drain; expected words come from an arithmetic reference model.
module tb_pe_block_drain;
    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [15:0]        base_addr;
    logic [15:0]        num_words;
    logic [4:0]         shift;
    logic               relu_en;
    logic               i_valid;
    logic signed [31:0] ofmap [0:7];
    logic               o_valid;
    logic               o_ready;
    logic [63:0]        o_data;
    logic [15:0]        o_addr;
    logic               busy;
    logic               done;
    logic               overflow;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_ready = 0;

    bit          m_started = 0;
    int          m_num, m_cap, m_kept, m_drop, m_popped;
    logic [15:0] m_base;
    int          m_sh;
    bit          m_relu;

    pe_block_drain dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .shift     (shift),
        .relu_en   (relu_en),
        .i_valid   (i_valid),
        .ofmap     (ofmap),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_addr    (o_addr),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-half-up division by 2^s using floor semantics, then ReLU and int8 clamp.
    function automatic logic [7:0] ref_q(input longint x, input int s, input bit relu);
        longint v, n, d;
        if (s == 0) begin
            v = x;
        end else begin
            d = longint'(1) << s;
            n = x + d / 2;
            v = n / d;
            if ((n % d) != 0 && n < 0) v = v - 1;
        end
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic bit m_running();
        return m_started && (m_popped + m_drop < m_num);
    endfunction

    task automatic do_start(input logic [15:0] b, input int n, input int s, input bit r);
        bit accept;
        accept    = !m_running();
        base_addr = b;
        num_words = 16'(n);
        shift     = 5'(s);
        relu_en   = r;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (accept) begin
            m_started = 1;
            m_base = b; m_num = n; m_sh = s; m_relu = r;
            m_cap = 0; m_kept = 0; m_drop = 0; m_popped = 0;
        end
    endtask

    // Called with ofmap already driven, just before the rising edge is presented.
    task automatic model_edge(input bit keep);
        exp_t e;
        if (m_started && m_cap < m_num) begin
            m_cap++;
            if (keep) begin
                e.addr = 16'(m_base + 16'(m_kept));
                for (int r = 0; r < 8; r++) e.data[r*8 +: 8] = ref_q(longint'(ofmap[r]), m_sh, m_relu);
                exp_q.push_back(e);
                m_kept++;
            end else begin
                m_drop++;
            end
        end
    endtask

    task automatic rand_ofmap();
        for (int r = 0; r < 8; r++) ofmap[r] = $signed($urandom()) >>> $urandom_range(0, 31);
    endtask

    task automatic pulse_rand(input bit keep);
        rand_ofmap();
        model_edge(keep);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 2000 && !done; i++) tick();
        chk(name, done, 1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
        chk(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_valid && o_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got addr=%0h data=%0h expected no word", o_addr, o_data);
            end else begin
                e = exp_q.pop_front();
                m_popped++;
                if (o_data !== e.data || o_addr !== e.addr) begin
                    errors++;
                    $display("FAIL word got addr=%0h data=%0h expected addr=%0h data=%0h",
                             o_addr, o_data, e.addr, e.data);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) o_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; shift = '0;
        relu_en = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        for (int r = 0; r < 8; r++) ofmap[r] = 0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_o_valid", o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_o_addr", o_addr, 0);
        chk("rst_o_data", o_data, 0);

        // Basic saturation and first-word latency
        o_ready = 1'b1;
        do_start(16'h100, 1, 0, 0);
        ofmap[0] = 5; ofmap[1] = -3; ofmap[2] = 127; ofmap[3] = 128;
        ofmap[4] = -129; ofmap[5] = 0; ofmap[6] = 1; ofmap[7] = -1;
        model_edge(1);
        i_valid = 1'b1;
        chk("lat_T_o_valid", o_valid, 0);
        tick();
        i_valid = 1'b0;
        chk("lat_T1_o_valid", o_valid, 0);
        tick();
        chk("lat_T2_o_valid", o_valid, 1);
        chk("basic_addr", o_addr, 64'h100);
        chk("basic_data", o_data, 64'hFF01_0080_7F7F_FD05);
        wait_done("basic_done");
        chk("basic_busy", busy, 0);

        // Rounding and ReLU
        do_start(16'h180, 1, 4, 1);
        ofmap[0] = 24; ofmap[1] = 23; ofmap[2] = -40; ofmap[3] = 4096;
        ofmap[4] = 7; ofmap[5] = 8; ofmap[6] = 0; ofmap[7] = -1;
        model_edge(1);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("round_data", o_data, 64'h0000_0100_7F00_0102);
        wait_done("round_done");

        // Backpressure: four words held, the fifth and sixth dropped
        o_ready = 1'b0;
        do_start(16'h200, 6, 0, 0);
        for (int k = 0; k < 6; k++) begin
            pulse_rand(k < 4);
            tick();
        end
        tick();
        chk("ovf_overflow", overflow, 1);
        chk("ovf_busy", busy, 1);
        chk("ovf_o_valid", o_valid, 1);
        chk("ovf_head_addr", o_addr, 64'h200);
        o_ready = 1'b1;
        wait_done("ovf_done");
        chk("ovf_sent", m_popped, 4);
        chk("ovf_sticky", overflow, 1);

        // Level i_valid gives a single capture per rising edge
        do_start(16'h400, 2, 2, 0);
        rand_ofmap();
        model_edge(1);
        i_valid = 1'b1;
        repeat (10) tick();
        i_valid = 1'b0;
        tick();
        wait_drain("level_drain");
        repeat (3) tick();
        chk("level_one_word", m_popped, 1);
        chk("level_busy", busy, 1);
        pulse_rand(1);
        wait_done("level_done");
        chk("level_two_words", m_popped, 2);

        // num_words == 0
        do_start(16'h0010, 0, 0, 0);
        chk("zero_busy", busy, 1);
        chk("zero_not_done", done, 0);
        tick();
        chk("zero_done", done, 1);
        chk("zero_busy_low", busy, 0);
        pulse_rand(1);
        repeat (3) tick();
        chk("zero_no_word", o_valid, 0);

        // start during RUN is ignored
        do_start(16'h300, 2, 1, 0);
        pulse_rand(1);
        wait_drain("midstart_drain");
        do_start(16'h500, 1, 0, 1);
        chk("midstart_busy", busy, 1);
        pulse_rand(1);
        wait_done("midstart_done");

        // Randomized runs with random backpressure
        rnd_ready = 1;
        for (int run = 0; run < 4; run++) begin
            do_start(16'($urandom()), $urandom_range(3, 8), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
            for (int w = 0; w < m_num; w++) begin
                for (int i = 0; i < 500 && exp_q.size() >= 3; i++) tick();
                pulse_rand(1);
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_done("rand_done");
            chk("rand_no_overflow", overflow, 0);
        end
        rnd_ready = 0;
        tick();

        // Reset with two words queued
        o_ready = 1'b0;
        do_start(16'h600, 4, 0, 0);
        pulse_rand(1);
        tick();
        pulse_rand(1);
        repeat (2) tick();
        chk("rstq_queued", o_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        m_started = 0;
        chk("rstq_o_valid", o_valid, 0);
        chk("rstq_busy", busy, 0);
        o_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_valid) cnt++;
        end
        chk("rstq_no_emit", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_block_drain.md
Name: pe_block_drain

Overview:
- Output-side consumer of the 8-row PE block.
- Captures each completed ofmap column (8 x 32-bit partial sums) when the block's valid rises.
- Requantizes each row to int8 (rounding right shift, optional ReLU, saturation) and packs the 8 results into one 64-bit word.
- Buffers words in a small FIFO and emits them on a valid/ready write port with incrementing addresses toward the output buffer.

Parameters:
- ROWS, 8, number of PE rows / ofmap lanes
- ACC_W, 32, width of each ofmap lane
- OUT_W, 8, requantized lane width (signed)
- FIFO_DEPTH, 4, output word FIFO entries (power of 2)
- ADDR_W, 16, output address width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; loads config, begins a run
- base_addr  input  ADDR_W  first output address, latched on start
- num_words  input  ADDR_W  words expected this run, latched on start
- shift  input  5  right-shift amount, latched on start
- relu_en  input  1  clamp negatives to 0, latched on start
- i_valid  input  1  PE block valid (level)
- ofmap  input  ACC_W x [0:ROWS-1]  PE block outputs, signed
- o_valid  output  1  output word available
- o_ready  input  1  downstream accepts word
- o_data  output  ROWS*OUT_W  packed word; lane r at bits [r*8+7:r*8]
- o_addr  output  ADDR_W  base_addr + words sent so far
- busy  output  1  high in RUN
- done  output  1  high in DONE
- overflow  output  1  sticky; a word was dropped on FIFO full

Behaviour:
- Reset (synchronous, active-high) clears:
  - all outputs to 0
  - FSM to IDLE
  - FIFO to empty
  - counters and the i_valid edge register
- FSM states:
  - IDLE: start -> RUN.
  - RUN: when sent_cnt + drop_cnt == num_words -> DONE.
  - DONE: start -> RUN.
  - start is ignored in RUN.
- On start:
  - latch base_addr, num_words, shift and relu_en
  - clear cap_cnt, sent_cnt, drop_cnt and overflow
  - if num_words == 0, enter RUN then move to DONE on the next cycle
- Capture:
  - Capture only in RUN, only on the i_valid rising edge (i_valid=1 and previous sample=0), and only while cap_cnt < num_words.
  - Edges outside these conditions are ignored.
  - Each capture increments cap_cnt.
- Requant per lane, combinational, applied in the capture cycle:
  - if shift > 0, v = (ofmap + (1 << (shift-1))) >>> shift, computed in 33-bit so the add cannot overflow; if shift == 0, v = ofmap
  - if relu_en and v < 0, v = 0
  - saturate to [-128, 127]
  - the result is registered into the stage register (stage_vld=1)
- FIFO write:
  - the cycle after capture, stage_vld writes the stage word into the FIFO
  - if the FIFO is full and no pop occurs that cycle, the word is dropped, drop_cnt increments and overflow is set
  - full with a simultaneous pop: the write is accepted
- Latency: i_valid edge in cycle T -> o_valid=1 in T+2 when the FIFO was empty (first-word fall-through).
- Output handshake:
  - o_valid = FIFO not empty
  - o_data = FIFO head
  - transfer happens when o_valid & o_ready; it pops the head and increments sent_cnt
  - o_addr = base_addr + sent_cnt, wrapping mod 2^ADDR_W
  - o_data and o_addr hold stable while o_valid=1 and o_ready=0
- A capture and a pop in the same cycle are both performed.
- busy = (state == RUN); done = (state == DONE), a level held until the next start.
- Reset mid-run discards FIFO contents and the stage word; no further o_valid.

Test Plan:
- Basic: start (base 0x100, num_words=1, shift=0, relu_en=0); ofmap lanes {5,-3,127,128,-129,0,1,-1}; i_valid pulse; o_ready=1 -> in T+2, o_valid=1, o_addr=0x100, o_data lanes {05,FD,7F,7F,80,00,01,FF}; done=1 after transfer.
- Rounding/ReLU: shift=4, relu_en=1; lanes {24,23,-40,4096,7,8,0,-1} -> {2,1,0,127,0,1,0,0}.
- Backpressure/overflow:
  - setup: num_words=6, o_ready=0, six i_valid edges spaced 3 cycles apart
  - required: FIFO_DEPTH=4 words held; words 5 and 6 dropped; overflow=1
  - then o_ready=1: addresses base..base+3 emitted; done=1
- Level i_valid: i_valid held high 10 cycles in RUN -> exactly one capture; a second capture only after i_valid drops and rises again.
- Boundaries:
  - num_words=0 -> done the cycle after RUN is entered
  - start during RUN -> ignored
  - rst asserted with 2 words queued -> o_valid=0 and busy=0 the next cycle; no emission afterward
